// File: rtl/jogador_automatico.sv
// Automatic player: listens to the game's LED sequence, stores it, and
// replays it on the buttons with fixed press and release durations.
module jogador_automatico #(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int IDLE_CYCLES  = 16,
  parameter int DEPTH        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       fim,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic [4:0] db_quantidade
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW   = $clog2(IDLE_CYCLES + 1);
  localparam int TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [4:0]    DEPTH_C    = 5'(DEPTH);
  localparam logic [IW-1:0] IDLE_C     = IW'(IDLE_CYCLES);
  localparam logic [TW-1:0] PRESS_LAST = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] FIRST_ADDR = '0;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    INICIA    = 4'd1,
    ESCUTA    = 4'd2,
    PRESSIONA = 4'd3,
    SOLTA     = 4'd4,
    FIM       = 4'd5
  } estado_t;

  estado_t       state_reg;
  logic [4:0]    count_reg;
  logic [4:0]    idx_reg;
  logic [IW-1:0] idle_reg;
  logic [3:0]    prev_reg;
  logic [TW-1:0] timer_reg;
  logic [3:0]    botoes_reg;
  logic          erro_reg;

  logic [3:0]    buffer_mem [DEPTH];

  logic          abort;
  logic          leds_one_hot;
  logic          capture_event;
  logic          capture_we;
  logic [4:0]    idx_next;
  logic [4:0]    count_last;

  // Game end has priority over everything else while the player is active.
  assign abort         = ganhou | perdeu;
  assign leds_one_hot  = (leds != 4'b0000) && ((leds & (leds - 4'd1)) == 4'b0000);
  // A new LED lighting up after a dark cycle is one displayed element.
  assign capture_event = (state_reg == ESCUTA) && (leds != 4'b0000) && (prev_reg == 4'b0000);
  assign capture_we    = capture_event && !abort && leds_one_hot && (count_reg < DEPTH_C);
  assign idx_next      = idx_reg + 5'd1;
  assign count_last    = count_reg - 5'd1;

  // Capture buffer write port; contents are only meaningful below count_reg.
  always_ff @(posedge clock) begin
    if (capture_we) begin
      buffer_mem[count_reg[AW-1:0]] <= leds;
    end
  end

  // Main controller: capture, replay timing, abort and restart handling.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= OCIOSO;
      count_reg  <= '0;
      idx_reg    <= '0;
      idle_reg   <= '0;
      prev_reg   <= '0;
      timer_reg  <= '0;
      botoes_reg <= '0;
      erro_reg   <= 1'b0;
    end else begin
      case (state_reg)
        OCIOSO: begin
          botoes_reg <= '0;
          if (iniciar) begin
            state_reg <= INICIA;
            count_reg <= '0;
            idx_reg   <= '0;
            idle_reg  <= '0;
            erro_reg  <= 1'b0;
          end
        end

        INICIA: begin
          botoes_reg <= '0;
          if (abort) begin
            state_reg <= FIM;
          end else begin
            prev_reg  <= leds;
            count_reg <= '0;
            idx_reg   <= '0;
            idle_reg  <= '0;
            erro_reg  <= 1'b0;
            state_reg <= ESCUTA;
          end
        end

        ESCUTA: begin
          if (abort) begin
            state_reg  <= FIM;
            botoes_reg <= '0;
          end else begin
            prev_reg <= leds;
            if (leds == 4'b0000) begin
              if (idle_reg != IDLE_C) idle_reg <= idle_reg + 1'b1;
            end else begin
              idle_reg <= '0;
            end
            if (capture_we) begin
              count_reg <= count_reg + 5'd1;
            end else if (capture_event) begin
              erro_reg <= 1'b1;
            end
            // Long enough darkness means the game finished showing the sequence.
            if ((idle_reg == IDLE_C) && (count_reg != 5'd0)) begin
              state_reg  <= PRESSIONA;
              idx_reg    <= '0;
              timer_reg  <= '0;
              botoes_reg <= buffer_mem[FIRST_ADDR];
            end
          end
        end

        PRESSIONA: begin
          if (abort) begin
            state_reg  <= FIM;
            botoes_reg <= '0;
          end else if (timer_reg == PRESS_LAST) begin
            state_reg  <= SOLTA;
            timer_reg  <= '0;
            botoes_reg <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        SOLTA: begin
          botoes_reg <= '0;
          if (abort) begin
            state_reg <= FIM;
          end else if (timer_reg == GAP_LAST) begin
            timer_reg <= '0;
            if (idx_reg == count_last) begin
              state_reg <= ESCUTA;
              count_reg <= '0;
              idx_reg   <= '0;
              idle_reg  <= '0;
              prev_reg  <= leds;
            end else begin
              state_reg  <= PRESSIONA;
              idx_reg    <= idx_next;
              botoes_reg <= buffer_mem[idx_next[AW-1:0]];
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        FIM: begin
          botoes_reg <= '0;
          if (iniciar) begin
            state_reg <= INICIA;
            count_reg <= '0;
            idx_reg   <= '0;
            idle_reg  <= '0;
            erro_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg  <= OCIOSO;
          botoes_reg <= '0;
        end
      endcase
    end
  end

  assign jogar         = (state_reg == INICIA);
  assign ocupado       = (state_reg == INICIA) || (state_reg == ESCUTA) ||
                         (state_reg == PRESSIONA) || (state_reg == SOLTA);
  assign fim           = (state_reg == FIM);
  assign db_estado     = state_reg;
  assign db_quantidade = count_reg;
  assign erro          = erro_reg;
  assign botoes        = botoes_reg;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for the automatic player: random LED phases checked against a
// queue-based model of which values must be captured and replayed.
module tb_jogador_automatico;

  localparam int PRESS = 4;
  localparam int GAP   = 4;
  localparam int IDLE  = 16;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] leds = 4'b0000;
  logic       ganhou = 1'b0;
  logic       perdeu = 1'b0;
  logic       jogar;
  logic [3:0] botoes;
  logic       ocupado;
  logic       fim;
  logic       erro;
  logic [3:0] db_estado;
  logic [4:0] db_quantidade;

  int checks = 0;
  int errors = 0;

  // model: values that must be replayed, and the sticky fault flag
  logic [3:0] acc_q[$];
  logic       model_err = 1'b0;

  // stimulus for one display phase
  logic [3:0] ev_val[$];
  int         ev_hold[$];
  int         ev_gap[$];

  jogador_automatico dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .leds(leds),
    .ganhou(ganhou),
    .perdeu(perdeu),
    .jogar(jogar),
    .botoes(botoes),
    .ocupado(ocupado),
    .fim(fim),
    .erro(erro),
    .db_estado(db_estado),
    .db_quantidade(db_quantidade)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic add_ev(input logic [3:0] v, input int h, input int g);
    ev_val.push_back(v);
    ev_hold.push_back(h);
    ev_gap.push_back(g);
  endtask

  function automatic logic [3:0] rand_onehot();
    return 4'(1 << $urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] rand_bad();
    logic [3:0] v;
    v = 4'($urandom_range(3, 15));
    while ($countones(v) < 2) v = 4'($urandom_range(3, 15));
    return v;
  endfunction

  // Show the queued events, then darkness; ends on the first replay cycle.
  task automatic capture_phase(input string name);
    int n;
    n = ev_val.size();
    $display("phase %s: %0d events", name, n);
    for (int i = 0; i < n; i++) begin
      leds = ev_val[i];
      if ($countones(ev_val[i]) == 1 && acc_q.size() < DEPTH) acc_q.push_back(ev_val[i]);
      else model_err = 1'b1;
      for (int c = 0; c < ev_hold[i]; c++) begin
        iniciar = 1'($urandom_range(0, 1));
        cyc();
        if (c == 0) begin
          chk("cap_state", db_estado, 2);
          chk("cap_count", db_quantidade, acc_q.size());
          chk("cap_erro", erro, model_err);
        end
      end
      leds = 4'b0000;
      if (i != n - 1) begin
        for (int g = 0; g < ev_gap[i]; g++) begin
          iniciar = 1'($urandom_range(0, 1));
          cyc();
        end
      end
    end
    iniciar = 1'b0;
    chk("idle_first", db_estado, 2);
    for (int k = 0; k < IDLE; k++) cyc();
    chk("idle_last", db_estado, 2);
    cyc();
    chk("replay_start", db_estado, 3);
    ev_val.delete();
    ev_hold.delete();
    ev_gap.delete();
  endtask

  task automatic replay_all();
    int n;
    n = acc_q.size();
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < PRESS; p++) begin
        chk("press_state", db_estado, 3);
        chk("press_val", botoes, acc_q[i]);
        cyc();
      end
      for (int g = 0; g < GAP; g++) begin
        chk("gap_state", db_estado, 4);
        chk("gap_val", botoes, 0);
        cyc();
      end
    end
    chk("back_state", db_estado, 2);
    chk("back_count", db_quantidade, 0);
    chk("back_erro", erro, model_err);
    chk("back_ocupado", ocupado, 1);
    $display("replay of %0d values done", n);
    acc_q.delete();
  endtask

  initial begin
    int n;
    logic [3:0] v;

    // reset state
    repeat (2) cyc();
    chk("rst_estado", db_estado, 0);
    chk("rst_botoes", botoes, 0);
    chk("rst_jogar", jogar, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_fim", fim, 0);
    chk("rst_erro", erro, 0);
    chk("rst_quant", db_quantidade, 0);
    reset = 1'b0;
    cyc();
    chk("idle_ocioso", db_estado, 0);

    // start pulse
    iniciar = 1'b1;
    chk("start_jogar0", jogar, 0);
    cyc();
    iniciar = 1'b0;
    chk("start_state1", db_estado, 1);
    chk("start_jogar1", jogar, 1);
    chk("start_ocupado", ocupado, 1);
    chk("start_quant", db_quantidade, 0);
    cyc();
    chk("start_state2", db_estado, 2);
    chk("start_jogar2", jogar, 0);
    $display("start sequence done");

    // round of three
    add_ev(4'b0001, 5, 3);
    add_ev(4'b0100, 5, 3);
    add_ev(4'b1000, 5, 3);
    capture_phase("round3");
    replay_all();

    // invalid LED pattern
    add_ev(4'b0010, 3, 2);
    add_ev(4'b0011, 3, 2);
    add_ev(4'b0001, 2, 2);
    capture_phase("invalid");
    replay_all();

    // overflow
    for (int i = 0; i < DEPTH + 1; i++)
      add_ev(rand_onehot(), $urandom_range(1, 3), $urandom_range(1, 3));
    capture_phase("overflow");
    replay_all();

    // random phases
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < n; i++) begin
        v = (i > 0 && $urandom_range(0, 9) == 0) ? rand_bad() : rand_onehot();
        add_ev(v, $urandom_range(1, 5), $urandom_range(1, 4));
      end
      capture_phase("random");
      replay_all();
    end

    // abort during the second press
    add_ev(4'b0010, 2, 2);
    add_ev(4'b1000, 2, 2);
    capture_phase("abort");
    for (int p = 0; p < PRESS; p++) begin
      chk("abort_p0", botoes, 4'b0010);
      cyc();
    end
    for (int g = 0; g < GAP; g++) cyc();
    chk("abort_p1", botoes, 4'b1000);
    perdeu = 1'b1;
    cyc();
    perdeu = 1'b0;
    chk("abort_state", db_estado, 5);
    chk("abort_fim", fim, 1);
    chk("abort_botoes", botoes, 0);
    chk("abort_ocupado", ocupado, 0);
    chk("abort_erro_hold", erro, model_err);
    repeat (3) cyc();
    chk("fim_hold", db_estado, 5);
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    chk("restart_state", db_estado, 1);
    chk("restart_erro", erro, 0);
    chk("restart_quant", db_quantidade, 0);
    chk("restart_jogar", jogar, 1);
    model_err = 1'b0;
    acc_q.delete();
    cyc();
    chk("restart_escuta", db_estado, 2);
    $display("abort sequence done");

    // asynchronous reset in the middle of a press
    add_ev(4'b0100, 2, 1);
    capture_phase("reset");
    chk("rst_press0", botoes, 4'b0100);
    cyc();
    chk("rst_press1", botoes, 4'b0100);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_botoes", botoes, 0);
    chk("arst_estado", db_estado, 0);
    chk("arst_ocupado", ocupado, 0);
    chk("arst_quant", db_quantidade, 0);
    chk("arst_erro", erro, 0);
    acc_q.delete();
    cyc();
    reset = 1'b0;
    cyc();
    chk("arst_after", db_estado, 0);
    $display("async reset sequence done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  PRESS_CYCLES, 4, cycles each button is held
  GAP_CYCLES, 4, cycles all buttons are released between presses
  IDLE_CYCLES, 16, consecutive all-zero leds cycles that end a display phase
  DEPTH, 16, capture buffer entries
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  clock  in  1  system clock, rising edge
  reset  in  1  asynchronous, active-high
  iniciar  in  1  request to start an automatic game
  leds  in  4  game LED outputs (one-hot or 0000)
  ganhou  in  1  game won flag
  perdeu  in  1  game lost flag
  jogar  out  1  one-cycle game start pulse
  botoes  out  4  emulated button presses
  ocupado  out  1  high in INICIA, ESCUTA, PRESSIONA, SOLTA
  fim  out  1  high in FIM
  erro  out  1  sticky capture fault flag
  db_estado  out  4  state code
  db_quantidade  out  5  entries captured, 0..DEPTH
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-010 FSM states and codes SHALL be OCIOSO=0, INICIA=1, ESCUTA=2, PRESSIONA=3, SOLTA=4, FIM=5; db_estado shows the code.
REQ-011 OCIOSO: all outputs 0; iniciar=1 -> INICIA on the next edge.
REQ-012 INICIA: jogar=1 for exactly this one cycle; count, index, idle counter and erro cleared; previous-leds register loaded with the current leds value; -> ESCUTA.
REQ-013 ESCUTA capture: an event is a cycle with leds!=0000 and previous-leds==0000; previous-leds updates every ESCUTA cycle.
REQ-014 Event with one-hot leds and count<DEPTH: write leds to buffer[count], count+1 on the same edge.
REQ-015 Event with count==DEPTH: no write, count holds, erro set.
REQ-016 Event with non-one-hot leds: no write, erro set.
REQ-017 Idle counter: +1 each ESCUTA cycle with leds==0000, cleared when leds!=0000, saturates at IDLE_CYCLES.
REQ-018 Idle counter==IDLE_CYCLES with count>0: -> PRESSIONA with index=0. With count==0: remain in ESCUTA.
REQ-019 PRESSIONA: botoes=buffer[index] for exactly PRESS_CYCLES cycles, then -> SOLTA.
REQ-020 SOLTA: botoes=0000 for exactly GAP_CYCLES cycles.
REQ-021 At the end of SOLTA with index<count-1: index+1 and -> PRESSIONA.
REQ-022 At the end of SOLTA with index==count-1: -> ESCUTA with count, index and idle counter cleared and previous-leds loaded with the current leds value.
REQ-023 ganhou or perdeu high in INICIA, ESCUTA, PRESSIONA or SOLTA: -> FIM on the next edge, overriding every other transition; botoes=0000 from that cycle.
REQ-024 FIM: fim=1, botoes=0000, buffer and erro hold; iniciar=1 -> INICIA.
REQ-025 iniciar SHALL be ignored in INICIA, ESCUTA, PRESSIONA and SOLTA.
REQ-026 botoes SHALL be registered and SHALL never be non-zero outside PRESSIONA.

Reset
REQ-030 Reset asserted at any time, including mid-press: state=OCIOSO immediately; jogar, botoes, ocupado, fim, erro and db_quantidade=0; db_estado=0.
REQ-031 Buffer contents need not be cleared by reset; count=0 makes them invalid.

Verification
REQ-040 Start: iniciar pulse in OCIOSO -> jogar high exactly 1 cycle, one cycle later; db_estado 0->1->2.
REQ-041 Round of 3: leds 0001, 0100, 1000, each shown for 5 cycles separated by 3 zero cycles, then 16 zero cycles -> botoes 0001, 0100, 1000, each for 4 cycles with 4 zero cycles between; then ESCUTA, db_quantidade=0.
REQ-042 Overflow: 17 one-hot events in one phase -> db_quantidade=16, erro=1, replay of the first 16 values only.
REQ-043 Invalid leds: leds=0011 event -> erro=1, db_quantidade unchanged.
REQ-044 Abort: perdeu=1 during the second press -> FIM next cycle, botoes=0000, fim=1; iniciar -> INICIA with erro=0.
REQ-045 Async reset asserted mid-PRESSIONA, between clock edges -> botoes=0000 and db_estado=0 without waiting for a clock edge.
